// File: rtl/op_issuer_pkg.sv
// Shared types for the operand issuer: FSM states,
// operation encoding and table entry layouts.
package op_issuer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_FINISH
    } state_e;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef struct packed {
        logic       add_sub;
        logic [7:0] a;
        logic [7:0] b;
    } operand_t;

    typedef struct packed {
        logic       ovf;
        logic [7:0] value;
    } result_t;

endpackage

// File: rtl/op_issuer_table.sv
// Small storage table: one write port, one registered read
// port returning freshly written data on a same-address hit.
module op_table #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // storage write
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // registered read; a write to the same entry is forwarded
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr == i_raddr)) r_rdata <= i_wdata;
        else                              r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/op_issuer.sv
// Walks the operand table through an external add/sub unit
// and stores each result and overflow flag in a result table.
module op_issuer
    import op_issuer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_a,
    input  logic [7:0]               wr_b,
    input  logic                     wr_add_sub,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_result,
    output logic                     rd_ovf,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic                     alu_add_sub,
    input  logic [7:0]               alu_result,
    input  logic                     alu_ovf,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e        r_state;
    logic [AW-1:0] r_idx;
    logic [CW-1:0] r_count;
    logic [1:0]    r_wait;
    logic [CW-1:0] r_ovf_cnt;
    logic          r_done;
    operand_t      r_alu;
    logic          r_rd_live;

    operand_t      w_op_wdata;
    operand_t      w_op_rdata;
    result_t       w_res_wdata;
    result_t       w_res_rdata;
    logic [AW-1:0] w_op_raddr;
    logic          w_op_we;
    logic          w_res_we;
    logic          w_last;
    logic          w_busy;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_op_we     = wr_en && !w_busy;
    assign w_op_wdata  = '{add_sub: wr_add_sub, a: wr_a, b: wr_b};
    assign w_res_we    = (r_state == ST_CAPTURE);
    assign w_res_wdata = '{ovf: alu_ovf, value: alu_result};
    assign w_last      = ((CW'(r_idx) + CW'(1)) == r_count);

    // operand prefetch: next entry is fetched during CAPTURE
    always_comb begin
        w_op_raddr = '0;
        unique case (r_state)
            ST_ISSUE, ST_WAIT: w_op_raddr = r_idx;
            ST_CAPTURE:        w_op_raddr = r_idx + AW'(1);
            default:           w_op_raddr = '0;
        endcase
    end

    op_table #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(operand_t))
    ) u_op_tbl (
        .clk     (clk),
        .i_we    (w_op_we),
        .i_waddr (wr_addr),
        .i_wdata (w_op_wdata),
        .i_raddr (w_op_raddr),
        .o_rdata (w_op_rdata)
    );

    op_table #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(result_t))
    ) u_res_tbl (
        .clk     (clk),
        .i_we    (w_res_we),
        .i_waddr (r_idx),
        .i_wdata (w_res_wdata),
        .i_raddr (rd_addr),
        .o_rdata (w_res_rdata)
    );

    // run sequencer: issue, wait out ALU latency, capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_count   <= '0;
            r_wait    <= '0;
            r_ovf_cnt <= '0;
            r_done    <= 1'b0;
            r_alu     <= '{add_sub: OP_SUB, a: '0, b: '0};
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ovf_cnt <= '0;
                        r_idx     <= '0;
                        r_count   <= count;
                        r_state   <= (count == '0) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_alu   <= w_op_rdata;
                    r_wait  <= '0;
                    r_state <= (ALU_LAT == 1) ? ST_CAPTURE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait == 2'(ALU_LAT - 2)) r_state <= ST_CAPTURE;
                    else                           r_wait  <= r_wait + 2'd1;
                end
                ST_CAPTURE: begin
                    if (alu_ovf) r_ovf_cnt <= r_ovf_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx   <= r_idx + AW'(1);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // read port shows zero until the first post-reset edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rd_live <= 1'b0;
        else       r_rd_live <= 1'b1;
    end

    // operands come straight from the table in ISSUE, then held
    assign alu_a       = (r_state == ST_ISSUE) ? w_op_rdata.a : r_alu.a;
    assign alu_b       = (r_state == ST_ISSUE) ? w_op_rdata.b : r_alu.b;
    assign alu_add_sub = (r_state == ST_ISSUE) ? w_op_rdata.add_sub
                                               : r_alu.add_sub;

    assign rd_result = r_rd_live ? w_res_rdata.value : 8'd0;
    assign rd_ovf    = r_rd_live ? w_res_rdata.ovf : 1'b0;
    assign busy      = w_busy;
    assign done      = r_done;
    assign ovf_cnt   = r_ovf_cnt;

endmodule
